// File: rtl/toggle_to_pulse.sv
// Receiver for two-phase toggle signalling: synchronizes `in`, turns each transition
// into a queued event, hands events out with valid/ready and returns an `ack` toggle.
module toggle_to_pulse #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in,
   input  logic                 ready,
   output logic                 out,
   output logic                 ack,
   output logic [CNT_WIDTH-1:0] pending,
   output logic                 overflow
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("toggle_to_pulse: SYNC_STAGES must be at least 2");
      end
   endgenerate

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   prev_reg;
   state_t                 state_reg;
   logic [CNT_WIDTH-1:0]   pending_reg;
   logic                   out_reg;
   logic                   ack_reg;
   logic                   overflow_reg;

   logic edge_det;
   logic take;

   // sync_reg[0] is the metastability-exposed stage; only the last stage is used.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_reg <= '0;
         prev_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], in};
         prev_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign edge_det = sync_reg[SYNC_STAGES-1] ^ prev_reg;
   assign take     = out_reg & ready;

   // The state mirrors the pending count so `out` can be registered rather than decoded.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_EMPTY;
         pending_reg  <= CNT_ZERO;
         out_reg      <= 1'b0;
         ack_reg      <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         if (take) begin
            ack_reg <= ~ack_reg;
         end
         case (state_reg)
            ST_EMPTY: begin
               if (edge_det) begin
                  pending_reg <= CNT_ONE;
                  out_reg     <= 1'b1;
                  state_reg   <= (CNT_ONE == CNT_MAX) ? ST_FULL : ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (edge_det && !take) begin
                  pending_reg <= pending_reg + CNT_ONE;
                  if (pending_reg + CNT_ONE == CNT_MAX) begin
                     state_reg <= ST_FULL;
                  end
               end else if (take && !edge_det) begin
                  pending_reg <= pending_reg - CNT_ONE;
                  if (pending_reg == CNT_ONE) begin
                     state_reg <= ST_EMPTY;
                     out_reg   <= 1'b0;
                  end
               end
            end
            ST_FULL: begin
               if (edge_det && !take) begin
                  overflow_reg <= 1'b1;
               end else if (take && !edge_det) begin
                  pending_reg <= CNT_MAX - CNT_ONE;
                  if (CNT_MAX == CNT_ONE) begin
                     state_reg <= ST_EMPTY;
                     out_reg   <= 1'b0;
                  end else begin
                     state_reg <= ST_HOLD;
                  end
               end
            end
            default: begin
               state_reg   <= ST_EMPTY;
               pending_reg <= CNT_ZERO;
               out_reg     <= 1'b0;
            end
         endcase
      end
   end

   assign out      = out_reg;
   assign ack      = ack_reg;
   assign pending  = pending_reg;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_toggle_to_pulse.sv
// Scoreboard bench for toggle_to_pulse: a default instance and a CNT_WIDTH=2 instance
// share stimulus; each consumed event is checked against a hand-computed queue entry.
module tb_toggle_to_pulse;

   logic       clock;
   logic       reset;
   logic       tog;
   logic       rdy;

   logic       d_out, d_ack, d_ovf;
   logic [3:0] d_pending;
   logic       s_out, s_ack, s_ovf;
   logic [1:0] s_pending;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int pending;
      int ack;
      int ovf;
   } exp_t;

   exp_t q_def[$];
   exp_t q_sat[$];
   exp_t e_def;
   exp_t e_sat;

   toggle_to_pulse u_def (
      .clock    (clock),
      .reset    (reset),
      .in       (tog),
      .ready    (rdy),
      .out      (d_out),
      .ack      (d_ack),
      .pending  (d_pending),
      .overflow (d_ovf)
   );

   toggle_to_pulse #(.SYNC_STAGES(2), .CNT_WIDTH(2)) u_sat (
      .clock    (clock),
      .reset    (reset),
      .in       (tog),
      .ready    (rdy),
      .out      (s_out),
      .ack      (s_ack),
      .pending  (s_pending),
      .overflow (s_ovf)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic void chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endfunction

   function automatic exp_t mk(input int p, input int a, input int o);
      exp_t r;
      r.pending = p;
      r.ack     = a;
      r.ovf     = o;
      return r;
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      tog   = 1'b0;
      rdy   = 1'b0;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
   endtask

   // Monitors: a take is decided in the cycle before the edge, so sample at negedge.
   always @(negedge clock) begin
      if (!reset && d_out && rdy) begin
         if (q_def.size() == 0) begin
            chk("def_unexpected_take", 1, 0);
         end else begin
            e_def = q_def.pop_front();
            @(posedge clock);
            #1;
            $display("take def: pending=%0d ack=%0d ovf=%0d", d_pending, d_ack, d_ovf);
            chk("def_take_pending", int'(d_pending), e_def.pending);
            chk("def_take_ack", int'(d_ack), e_def.ack);
            chk("def_take_ovf", int'(d_ovf), e_def.ovf);
         end
      end
   end

   always @(negedge clock) begin
      if (!reset && s_out && rdy) begin
         if (q_sat.size() == 0) begin
            chk("sat_unexpected_take", 1, 0);
         end else begin
            e_sat = q_sat.pop_front();
            @(posedge clock);
            #1;
            $display("take sat: pending=%0d ack=%0d ovf=%0d", s_pending, s_ack, s_ovf);
            chk("sat_take_pending", int'(s_pending), e_sat.pending);
            chk("sat_take_ack", int'(s_ack), e_sat.ack);
            chk("sat_take_ovf", int'(s_ovf), e_sat.ovf);
         end
      end
   end

   initial begin
      // Reset and idle
      reset = 1'b1;
      tog   = 1'b0;
      rdy   = 1'b0;
      tick(1);
      chk("reset_def_state", int'({d_out, d_pending, d_ack, d_ovf}), 0);
      chk("reset_sat_state", int'({s_out, s_pending, s_ack, s_ovf}), 0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("idle_def_state", int'({d_out, d_pending, d_ack, d_ovf}), 0);
         chk("idle_sat_state", int'({s_out, s_pending, s_ack, s_ovf}), 0);
      end

      // Single event: out high for exactly the cycle after edge 2, ack flips at edge 3
      rdy = 1'b1;
      q_def.push_back(mk(0, 1, 0));
      q_sat.push_back(mk(0, 1, 0));
      tog = 1'b1;
      tick(2);
      chk("single_out_edge1", int'(d_out), 0);
      tick(1);
      chk("single_out_edge2", int'(d_out), 1);
      chk("single_pending_edge2", int'(d_pending), 1);
      tick(1);
      chk("single_out_edge3", int'(d_out), 0);
      chk("single_ack_edge3", int'(d_ack), 1);
      tick(1);
      chk("single_out_edge4", int'(d_out), 0);

      // Queueing three events, then draining
      do_reset();
      tog = 1'b1; tick(4);
      tog = 1'b0; tick(4);
      tog = 1'b1; tick(4);
      chk("queue_def_pending", int'(d_pending), 3);
      chk("queue_sat_pending", int'(s_pending), 3);
      chk("queue_def_out", int'(d_out), 1);
      q_def.push_back(mk(2, 1, 0)); q_def.push_back(mk(1, 0, 0)); q_def.push_back(mk(0, 1, 0));
      q_sat.push_back(mk(2, 1, 0)); q_sat.push_back(mk(1, 0, 0)); q_sat.push_back(mk(0, 1, 0));
      rdy = 1'b1;
      tick(3);
      rdy = 1'b0;
      tick(1);
      chk("queue_def_out_drained", int'(d_out), 0);
      chk("queue_sat_out_drained", int'(s_out), 0);

      // Saturation: four events, narrow instance holds 3 and flags overflow
      do_reset();
      tog = 1'b1; tick(2);
      tog = 1'b0; tick(2);
      tog = 1'b1; tick(2);
      tog = 1'b0; tick(2);
      chk("sat_pending_before_4th", int'(s_pending), 3);
      chk("sat_ovf_before_4th", int'(s_ovf), 0);
      tick(1);
      chk("sat_pending_after_4th", int'(s_pending), 3);
      chk("sat_ovf_after_4th", int'(s_ovf), 1);
      chk("def_pending_after_4th", int'(d_pending), 4);
      chk("def_ovf_after_4th", int'(d_ovf), 0);
      q_sat.push_back(mk(2, 1, 1)); q_sat.push_back(mk(1, 0, 1)); q_sat.push_back(mk(0, 1, 1));
      q_def.push_back(mk(3, 1, 0)); q_def.push_back(mk(2, 0, 0));
      q_def.push_back(mk(1, 1, 0)); q_def.push_back(mk(0, 0, 0));
      rdy = 1'b1;
      tick(4);
      rdy = 1'b0;
      tick(1);
      chk("sat_pending_drained", int'(s_pending), 0);
      chk("sat_ovf_sticky", int'(s_ovf), 1);
      chk("def_pending_drained", int'(d_pending), 0);

      // Simultaneous edge and take while FULL
      do_reset();
      chk("sim_sat_ovf_cleared", int'(s_ovf), 0);
      tog = 1'b1; tick(2);
      tog = 1'b0; tick(2);
      tog = 1'b1; tick(2);
      tog = 1'b0; tick(1);
      chk("sim_sat_pending_full", int'(s_pending), 3);
      tick(1);
      q_sat.push_back(mk(3, 1, 0));
      q_def.push_back(mk(3, 1, 0));
      rdy = 1'b1;
      tick(1);
      rdy = 1'b0;
      tick(1);
      chk("sim_sat_pending_after", int'(s_pending), 3);
      chk("sim_sat_ovf_after", int'(s_ovf), 0);

      // Asynchronous reset between edges while holding two events
      do_reset();
      tog = 1'b1; tick(2);
      tog = 1'b0; tick(4);
      chk("areset_def_pending_before", int'(d_pending), 2);
      #2;
      reset = 1'b1;
      #1;
      chk("areset_def_state", int'({d_out, d_pending, d_ack, d_ovf}), 0);
      chk("areset_sat_state", int'({s_out, s_pending, s_ack, s_ovf}), 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      tick(3);

      chk("def_queue_empty", q_def.size(), 0);
      chk("sat_queue_empty", q_sat.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
